bitwise_16_arbiter: RTL and testbench
=====================================

BITWISE_16_ARBITER -- requirements
Module: bitwise_16_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 operation request; held high until gnt0.
REQ-005 a0, b0  input  WIDTH  requester 0 operands.
REQ-006 op0  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOT a.
REQ-007 req1, a1, b1, op1  input  1/WIDTH/WIDTH/2  requester 1, same meaning as requester 0.
REQ-008 gnt0, gnt1  output  1  registered grant; one-cycle pulse in EXEC.
REQ-009 done0, done1  output  1  registered completion; one-cycle pulse in DONE.
REQ-010 out  output  WIDTH  registered result; valid while done0 or done1 is high, held afterwards.
REQ-011 busy  output  1  high in EXEC and DONE.

Function
REQ-012 FSM states: IDLE, EXEC, DONE; one shared bitwise unit computes all results.
REQ-013 IDLE: no request -> stay IDLE. Any request -> capture the winner's a, b and op plus a 1-bit owner register at the edge; next state EXEC.
REQ-014 Arbitration happens only in IDLE; req0/req1 are ignored in EXEC and DONE.
REQ-015 Single request: granted regardless of priority pointer.
REQ-016 Both requests: grant to the requester selected by the 1-bit priority pointer prio (0 -> requester 0, 1 -> requester 1).
REQ-017 After every grant, prio = inverse of the owner (round-robin); prio is unchanged when no grant occurs.
REQ-018 EXEC lasts exactly one cycle: gnt_owner = 1, other grant = 0. At the EXEC->DONE edge, out = the op applied to the captured operands.
REQ-019 DONE lasts exactly one cycle: done_owner = 1, other done = 0. Next state is IDLE unconditionally.
REQ-020 Latency: request sampled at edge N -> gnt high in cycle N+1 -> done high and out valid in cycle N+2 -> IDLE in cycle N+3.
REQ-021 Throughput: at most one operation per 3 cycles.
REQ-022 A requester deasserts req in its gnt cycle. A req still high when the FSM reaches IDLE counts as a new request.
REQ-023 Operands are captured at grant. Operand changes after the grant edge do not affect out.
REQ-024 Results are bitwise, exactly WIDTH bits, with no carry or overflow. NOT ignores b.
REQ-025 out retains its last result through IDLE and EXEC until the next DONE.
REQ-026 gnt0 and gnt1 are never high together. done0 and done1 are never high together.

Reset
REQ-027 rst_n low forces, immediately and asynchronously: state = IDLE, prio = 0, owner = 0, out = 0, gnt0 = gnt1 = done0 = done1 = busy = 0.
REQ-028 Reset asserted during EXEC or DONE aborts the operation. No done pulse is produced for it.
REQ-029 After rst_n rises, the first edge with a request performs normal arbitration with prio = 0.

Verification
REQ-030 Single AND: req0 = 1, a0 = 16'h1234, b0 = 16'h9876, op0 = 00 -> gnt0 in cycle N+1, done0 in cycle N+2 with out = 16'h1034; busy high in cycles N+1..N+2.
REQ-031 Contention: req0 and req1 both high after reset. Requester 0 has a0 = 16'hAAAA, b0 = 16'h5555, op0 = 10; requester 1 has a1 = 16'h0000, op1 = 11. Requester 0 is served first with out = 16'hFFFF. Requester 1 is served next (gnt1 in the following IDLE+1) with out = 16'hFFFF.
REQ-032 Fairness: both requesters held continuously high for 6 grants -> grant order 0,1,0,1,0,1; never two consecutive grants to the same requester.
REQ-033 Operand isolation: requester 1 with a1 = 16'hF0F0, b1 = 16'h0FF0, op1 = 01 changes a1 to 16'h0000 in its gnt cycle -> out = 16'hFFF0 at done1.
REQ-034 Reset mid-op: rst_n pulled low in an EXEC cycle -> all outputs 0 in that same cycle without waiting for an edge; no done pulse. After rst_n rises, a fresh req1 alone is granted with standard latency.
REQ-035 Hold: after the REQ-030 result, both requests stay low for 5 cycles -> out stays 16'h1034, busy stays 0, no grant or done pulses.

Source files
------------

// File: rtl/bitwise_16_arbiter.sv
// Two-requester arbiter in front of one shared bitwise unit (AND/OR/XOR/NOT a), round-robin on contention.
// Latency: gnt pulses the cycle after the sampling edge, done + out the cycle after that; one op per 3 cycles.
// Backpressure: requesters hold req until their gnt pulse; req is only sampled while IDLE, ignored otherwise.
module bitwise_16_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [1:0]       op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation captured at grant time so later operand changes cannot leak into the result.
    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    state_t           state;
    logic             prio;
    logic             owner;
    cmd_t             cmd;
    cmd_t             win_cmd;
    logic             pick1;
    logic [WIDTH-1:0] result;

    // Winner selection: a lone request wins outright, contention is settled by the priority pointer.
    always_comb begin
        pick1   = req1 & (~req0 | prio);
        win_cmd = pick1 ? {op1, a1, b1} : {op0, a0, b0};
    end

    // Shared bitwise unit operating on the captured command; NOT ignores b.
    always_comb begin
        result = '0;
        case (cmd.op)
            2'b00:   result = cmd.a & cmd.b;
            2'b01:   result = cmd.a | cmd.b;
            2'b10:   result = cmd.a ^ cmd.b;
            default: result = ~cmd.a;
        endcase
    end

    // Control FSM: IDLE arbitrates and captures, EXEC grants and computes, DONE signals completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            cmd   <= '0;
            out   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (req0 || req1) begin
                        cmd   <= win_cmd;
                        owner <= pick1;
                        prio  <= ~pick1;
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    out   <= result;
                    done0 <= ~owner;
                    done1 <= owner;
                    state <= DONE;
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_16_arbiter.sv
// Bench for bitwise_16_arbiter: directed scenarios with literal expectations plus randomized traffic.
// Outputs are compared every falling edge against a timeline model of grants, results and pulses.
// Stimulus changes 1 time unit after each rising edge; the model samples requests on the rising edge.
module tb_bitwise_16_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   op0 = '0, op1 = '0;
    logic         gnt0, gnt1, done0, done1, busy;
    logic [W-1:0] out;

    int n_checks = 0;
    int n_errors = 0;

    bitwise_16_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (timeline of the last grant) ----------------
    int           cyc = 0;
    int           g_cyc = -100;
    bit           m_prio = 1'b0;
    bit           m_own = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_held = '0;

    function automatic logic [W-1:0] bitop(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prio = 1'b0;
            m_own  = 1'b0;
            g_cyc  = -100;
            m_res  = '0;
            m_held = '0;
        end else begin
            cyc++;
            // free again three edges after the previous grant
            if (cyc >= g_cyc + 3 && (req0 || req1)) begin
                bit w;
                w      = (req0 && req1) ? m_prio : req1;
                m_held = m_res;
                m_res  = w ? bitop(op1, a1, b1) : bitop(op0, a0, b0);
                m_own  = w;
                m_prio = !w;
                g_cyc  = cyc;
            end
        end
    end

    function automatic logic [W+4:0] pack_dut();
        return {gnt0, gnt1, done0, done1, busy, out};
    endfunction

    function automatic logic [W+4:0] ex(bit g0, bit g1, bit d0, bit d1, bit bz, logic [W-1:0] o);
        return {g0, g1, d0, d1, bz, o};
    endfunction

    task automatic check(string nm, logic [W+4:0] got, logic [W+4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got {g0,g1,d0,d1,busy,out}=%h expected %h", nm, $time, got, exp);
        end
    endtask

    // Continuous comparison against the model whenever reset is released.
    always @(negedge clk) begin
        if (rst_n) begin
            bit g, d, bz;
            g  = (cyc == g_cyc);
            d  = (cyc == g_cyc + 1);
            bz = g || d;
            check("model", pack_dut(),
                  ex(g && !m_own, g && m_own, d && !m_own, d && m_own, bz,
                     (cyc >= g_cyc + 1) ? m_res : m_held));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string nm, logic [W+4:0] exp);
        @(negedge clk);
        check(nm, pack_dut(), exp);
    endtask

    task automatic reset_dut();
        req0 = 1'b0;
        req1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_state", pack_dut(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int who, prev;
        bit got;

        // reset and idle state
        reset_dut();
        lit("post_reset_idle", '0);

        // single AND, then hold with no requests
        tick(); req0 = 1; a0 = 16'h1234; b0 = 16'h9876; op0 = 2'b00;
        tick(); req0 = 0; a0 = 16'hDEAD;
        lit("and_gnt", ex(1, 0, 0, 0, 1, 16'h0000));
        lit("and_done", ex(0, 0, 1, 0, 1, 16'h1034));
        for (int i = 0; i < 6; i++) lit("hold", ex(0, 0, 0, 0, 0, 16'h1034));

        // contention right after reset: requester 0 first, then 1
        reset_dut();
        tick(); req0 = 1; a0 = 16'hAAAA; b0 = 16'h5555; op0 = 2'b10;
                req1 = 1; a1 = 16'h0000; b1 = 16'h1357; op1 = 2'b11;
        tick(); req0 = 0;
        lit("cont_gnt0", ex(1, 0, 0, 0, 1, 16'h0000));
        lit("cont_done0", ex(0, 0, 1, 0, 1, 16'hFFFF));
        lit("cont_idle", ex(0, 0, 0, 0, 0, 16'hFFFF));
        tick(); req1 = 0;
        lit("cont_gnt1", ex(0, 1, 0, 0, 1, 16'hFFFF));
        lit("cont_done1", ex(0, 0, 0, 1, 1, 16'hFFFF));

        // fairness: both held high for six grants
        reset_dut();
        tick(); req0 = 1; req1 = 1;
        a0 = 16'h0F0F; b0 = 16'h00FF; op0 = 2'b00;
        a1 = 16'h3C3C; b1 = 16'hFF00; op1 = 2'b10;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            got = 0;
            who = -1;
            for (int t = 0; t < 8 && !got; t++) begin
                @(negedge clk);
                if (gnt0 || gnt1) begin
                    got = 1;
                    who = gnt1 ? 1 : 0;
                end
            end
            n_checks++;
            if (!got || who != (k % 2) || who == prev) begin
                n_errors++;
                $display("FAIL fair_order grant %0d got requester %0d expected %0d", k, who, k % 2);
            end
            prev = who;
        end
        tick(); req0 = 0; req1 = 0;
        repeat (4) tick();

        // operand isolation: a1 changes in the gnt cycle
        reset_dut();
        tick(); req1 = 1; a1 = 16'hF0F0; b1 = 16'h0FF0; op1 = 2'b01;
        tick(); req1 = 0; a1 = 16'h0000;
        lit("iso_gnt1", ex(0, 1, 0, 0, 1, 16'h0000));
        lit("iso_done1", ex(0, 0, 0, 1, 1, 16'hFFF0));

        // reset during EXEC: outputs clear immediately, no done pulse
        tick(); req0 = 1; a0 = 16'hFFFF; b0 = 16'hFFFF; op0 = 2'b00;
        tick(); req0 = 0;
        #1;
        check("pre_rst_exec", pack_dut(), ex(1, 0, 0, 0, 1, 16'hFFF0));
        rst_n = 0;
        #1;
        check("rst_async", pack_dut(), '0);
        lit("rst_hold_a", '0);
        lit("rst_hold_b", '0);
        tick(); rst_n = 1;
        lit("rst_no_done", '0);
        tick(); req1 = 1; a1 = 16'h1234; b1 = 16'h00FF; op1 = 2'b00;
        tick(); req1 = 0;
        lit("post_rst_gnt1", ex(0, 1, 0, 0, 1, 16'h0000));
        lit("post_rst_done1", ex(0, 0, 0, 1, 1, 16'h0034));

        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i == 1500) reset_dut();
            if (gnt0) begin
                a0 = W'($urandom); b0 = W'($urandom); op0 = 2'($urandom);
                req0 = ($urandom_range(0, 3) == 0);
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; a0 = W'($urandom); b0 = W'($urandom); op0 = 2'($urandom);
            end
            if (gnt1) begin
                a1 = W'($urandom); b1 = W'($urandom); op1 = 2'($urandom);
                req1 = ($urandom_range(0, 3) == 0);
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; a1 = W'($urandom); b1 = W'($urandom); op1 = 2'($urandom);
            end
        end
        req0 = 0;
        req1 = 0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
